dsp_result_collector: RTL and testbench

Reader end of the DSP48A1 datapath. It tracks operands issued into the multiply/accumulate pipeline and captures each P result when it emerges after the configured register latency. Captured results are buffered in a small FIFO and handed downstream on a valid/ready stream. Credit-based issue throttling guarantees that no result is ever dropped.

---
 rtl/dsp_collector_pkg.sv | 15 +
 rtl/dsp_collector_fifo.sv | 68 ++++++
 rtl/dsp_result_collector.sv | 126 ++++++++++++
 tb/tb_dsp_result_collector.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_collector_pkg.sv
// Shared constants and helpers for the DSP48A1 result collector.
package dsp_collector_pkg;

    localparam int DSP_P_WIDTH     = 48;
    localparam int DSP_MAX_LATENCY = 4;
    localparam int DSP_TAG_WIDTH   = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/dsp_collector_fifo.sv
// Show-ahead FIFO for captured DSP results; rd_data is always mem[rd_ptr].
// DEPTH must be a power of two so the pointers wrap by overflow.
module dsp_collector_fifo
    import dsp_collector_pkg::*;
#(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH),
    localparam int LW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic                        wr_fire;
    logic                        rd_fire;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign rd_fire = rd_en & ~empty;
    // A simultaneous read frees the slot, so a write at full is still accepted.
    assign wr_fire = wr_en & (~full | rd_fire);
    assign rd_data = mem[rd_ptr];

    // Storage is reset so the head reads as zero out of reset; flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (wr_fire && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
            if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
            if (wr_fire && !rd_fire)      level <= level + LW'(1);
            else if (rd_fire && !wr_fire) level <= level - LW'(1);
        end
    end

`ifndef SYNTHESIS
    overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && full && !rd_en && !flush))
        else $error("dsp_collector_fifo: write while full was dropped");
`endif

endmodule

// File: rtl/dsp_result_collector.sv
// Tracks operands issued into the DSP pipeline and captures P after LATENCY CE-qualified
// stages into a credit-throttled FIFO. Define DSP_COLLECTOR_TAG_EN to carry a 4-bit tag.
module dsp_result_collector
    import dsp_collector_pkg::*;
#(
    parameter  int P_WIDTH = DSP_P_WIDTH,
    parameter  int LATENCY = 2,
    parameter  int DEPTH   = 4,
    localparam int CW      = clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     flush,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [P_WIDTH-1:0]       p_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [P_WIDTH-1:0]       out_data,
`ifdef DSP_COLLECTOR_TAG_EN
    input  logic [DSP_TAG_WIDTH-1:0] issue_tag,
    output logic [DSP_TAG_WIDTH-1:0] out_tag,
`endif
    output logic [CW-1:0]            level,
    output logic [CW-1:0]            in_flight
);

`ifdef DSP_COLLECTOR_TAG_EN
    localparam int FW = P_WIDTH + DSP_TAG_WIDTH;
    logic [DSP_TAG_WIDTH-1:0] cap_tag;
`else
    localparam int FW = P_WIDTH;
`endif

    logic          issue_fire;
    logic          cap;
    logic          full;
    logic          empty;
    logic [CW:0]   credits_used;
    logic [FW-1:0] wr_data;
    logic [FW-1:0] rd_data;

    // Every in-flight result owns a FIFO slot, so a capture can never find the FIFO full.
    assign credits_used = {1'b0, in_flight} + {1'b0, level};
    assign issue_ready  = credits_used < (CW + 1)'(DEPTH);
    assign issue_fire   = issue_valid & issue_ready & ce;
    assign out_valid    = ~empty;

    generate
        if (LATENCY == 0) begin : g_lat0
            assign cap = issue_fire;
`ifdef DSP_COLLECTOR_TAG_EN
            assign cap_tag = issue_tag;
`endif
        end else begin : g_lat
            logic [LATENCY-1:0] vld_pipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe <= '0;
                end else if (flush) begin
                    vld_pipe <= '0;
                end else if (ce) begin
                    vld_pipe[0] <= issue_fire;
                    for (int i = 1; i < LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
                end
            end

            // Capture only on a CE cycle, when the DSP P register has actually advanced.
            assign cap = vld_pipe[LATENCY-1] & ce;

`ifdef DSP_COLLECTOR_TAG_EN
            logic [LATENCY-1:0][DSP_TAG_WIDTH-1:0] tag_pipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tag_pipe <= '0;
                end else if (ce) begin
                    tag_pipe[0] <= issue_tag;
                    for (int i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
                end
            end

            assign cap_tag = tag_pipe[LATENCY-1];
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= '0;
        end else if (flush) begin
            in_flight <= '0;
        end else if (issue_fire && !cap) begin
            in_flight <= in_flight + CW'(1);
        end else if (cap && !issue_fire) begin
            in_flight <= in_flight - CW'(1);
        end
    end

`ifdef DSP_COLLECTOR_TAG_EN
    assign wr_data           = {cap_tag, p_in};
    assign {out_tag, out_data} = rd_data;
`else
    assign wr_data  = p_in;
    assign out_data = rd_data;
`endif

    dsp_collector_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (cap),
        .wr_data (wr_data),
        .rd_en   (out_ready),
        .rd_data (rd_data),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_dsp_result_collector.sv
// Self-checking bench for dsp_result_collector: directed scenarios plus randomized traffic
// against a queue-based reference model and a behavioural DSP pipeline that drives p_in.
module tb_dsp_result_collector;

    localparam int PW    = 48;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic          flush;
    logic          issue_valid;
    logic          issue_ready;
    logic [PW-1:0] p_in;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic [CW-1:0] level;
    logic [CW-1:0] in_flight;

    logic [PW-1:0] op_val;

    int checks = 0;
    int errors = 0;

    // Reference state: pending issues with remaining CE cycles, and the FIFO contents.
    logic [PW-1:0] pv[$];
    int            pr[$];
    logic [PW-1:0] fq[$];
    // Behavioural DSP pipeline registers (clocked by CE) feeding p_in.
    logic [PW-1:0] dp[LAT];

    always #5 clk = ~clk;

    dsp_result_collector #(
        .P_WIDTH (PW),
        .LATENCY (LAT),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .p_in        (p_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .in_flight   (in_flight)
    );

    task automatic model_clear();
        pv.delete();
        pr.delete();
        fq.delete();
    endtask

    // Advance model and DSP environment by one clock; returns at posedge+1.
    task automatic tick();
        bit m_ready;
        bit fire;
        @(negedge clk);
        m_ready = (pv.size() + fq.size()) < DEPTH;
        fire    = issue_valid && m_ready && ce;
        if (flush) begin
            model_clear();
        end else begin
            if (out_ready && fq.size() != 0) void'(fq.pop_front());
            if (ce) begin
                foreach (pr[i]) pr[i] = pr[i] - 1;
                while (pr.size() != 0 && pr[0] == 0) begin
                    fq.push_back(pv.pop_front());
                    void'(pr.pop_front());
                end
            end
            if (fire) begin
                if (LAT == 0) fq.push_back(op_val);
                else begin
                    pv.push_back(op_val);
                    pr.push_back(LAT);
                end
            end
        end
        if (ce) begin
            for (int i = LAT - 1; i > 0; i--) dp[i] = dp[i-1];
            dp[0] = op_val;
        end
        @(posedge clk);
        #1;
        p_in = dp[LAT-1];
    endtask

    task automatic drain();
        issue_valid = 0; flush = 0; ce = 1; out_ready = 1;
        repeat (LAT + DEPTH + 2) tick();
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %0b want 1", issue_ready); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (in_flight !== '0) begin errors++; $display("FAIL reset_in_flight got %0d want 0", in_flight); end
    endtask

    task automatic test_single();
        drain();
        issue_valid = 1; op_val = 48'h0000_0000_ABCD;
        tick();
        issue_valid = 0; op_val = 48'h5555;
        checks++; if (in_flight !== 3'd1) begin errors++; $display("FAIL single_in_flight_c1 got %0d want 1", in_flight); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
        checks++; if (out_data !== 48'hABCD) begin errors++; $display("FAIL single_data got %h want %h", out_data, 48'hABCD); end
        checks++; if (in_flight !== 3'd0) begin errors++; $display("FAIL single_in_flight_c3 got %0d want 0", in_flight); end
        tick();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_consumed_level got %0d want 0", level); end
    endtask

    task automatic test_credit_fill();
        drain();
        out_ready = 0; issue_valid = 1;
        for (int k = 0; k < 10; k++) begin
            op_val = PW'(k);
            checks++;
            if (issue_ready !== (k < DEPTH)) begin
                errors++; $display("FAIL fill_issue_ready k=%0d got %0b want %0b", k, issue_ready, (k < DEPTH));
            end
            tick();
        end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level got %0d want 4", level); end
        checks++; if (in_flight !== 3'd0) begin errors++; $display("FAIL fill_in_flight got %0d want 0", in_flight); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full got %0b want 0", issue_ready); end
        issue_valid = 0; out_ready = 1;
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (out_data !== PW'(k) || level !== CW'(DEPTH - k)) begin
                errors++; $display("FAIL fill_drain k=%0d got data %0d level %0d want data %0d level %0d",
                                   k, out_data, level, k, DEPTH - k);
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_drained_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_ce_stall();
        drain();
        out_ready = 0; issue_valid = 1; op_val = 48'hA1;
        tick();
        issue_valid = 0;
        repeat (3) tick();
        issue_valid = 1; op_val = 48'hB2;
        tick();
        issue_valid = 0; ce = 0; out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_flight !== 3'd1) begin errors++; $display("FAIL stall_in_flight k=%0d got %0d want 1", k, in_flight); end
            tick();
        end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL stall_read_during_ce0 got level %0d want 0", level); end
        ce = 1; out_ready = 0;
        tick();
        checks++; if (in_flight !== 3'd1 || level !== 3'd0) begin
            errors++; $display("FAIL stall_pre_cap got in_flight %0d level %0d want 1 0", in_flight, level);
        end
        tick();
        checks++; if (level !== 3'd1 || in_flight !== 3'd0 || out_data !== 48'hB2) begin
            errors++; $display("FAIL stall_cap got level %0d in_flight %0d data %h want 1 0 b2", level, in_flight, out_data);
        end
    endtask

    task automatic test_back_to_back();
        drain();
        out_ready = 0; issue_valid = 1;
        for (int k = 0; k < 4; k++) begin op_val = PW'(40 + k); tick(); end
        issue_valid = 0;
        tick();
        checks++; if (level !== 3'd3 || in_flight !== 3'd1 || out_data !== PW'(40)) begin
            errors++; $display("FAIL b2b_setup got level %0d in_flight %0d data %0d want 3 1 40", level, in_flight, out_data);
        end
        out_ready = 1;
        tick();
        checks++; if (level !== 3'd3 || in_flight !== 3'd0) begin
            errors++; $display("FAIL b2b_rw_level got level %0d in_flight %0d want 3 0", level, in_flight);
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== PW'(40 + k)) begin
                errors++; $display("FAIL b2b_order k=%0d got valid %0b data %0d want 1 %0d", k, out_valid, out_data, 40 + k);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drain();
        out_ready = 0; issue_valid = 1;
        for (int k = 0; k < 4; k++) begin op_val = PW'(60 + k); tick(); end
        issue_valid = 0;
        checks++; if (level !== 3'd2 || in_flight !== 3'd2) begin
            errors++; $display("FAIL areset_setup got level %0d in_flight %0d want 2 2", level, in_flight);
        end
        #2 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || level !== '0 || in_flight !== '0 || issue_ready !== 1'b1) begin
            errors++; $display("FAIL areset_immediate got valid %0b level %0d in_flight %0d ready %0b want 0 0 0 1",
                               out_valid, level, in_flight, issue_ready);
        end
        model_clear();
        #3 rst_n = 1;
        @(posedge clk);
        #1;
        ce = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (level !== '0 || in_flight !== '0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL areset_stale k=%0d got level %0d in_flight %0d valid %0b want 0 0 0",
                                   k, level, in_flight, out_valid);
            end
        end
    endtask

    task automatic test_flush();
        drain();
        out_ready = 0; issue_valid = 1;
        for (int k = 0; k < 3; k++) begin op_val = PW'(80 + k); tick(); end
        issue_valid = 0;
        repeat (2) tick();
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL flush_setup got level %0d want 3", level); end
        flush = 1; issue_valid = 1; op_val = 48'hF00D;
        tick();
        flush = 0; issue_valid = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (level !== '0 || in_flight !== '0 || out_valid !== 1'b0 || issue_ready !== 1'b1) begin
                errors++; $display("FAIL flush_clear k=%0d got level %0d in_flight %0d valid %0b ready %0b want 0 0 0 1",
                                   k, level, in_flight, out_valid, issue_ready);
            end
            tick();
        end
    endtask

    task automatic test_random();
        drain();
        for (int n = 0; n < 400; n++) begin
            issue_valid = ($urandom_range(0, 9) < 7);
            ce          = ($urandom_range(0, 9) < 8);
            out_ready   = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 59) == 0);
            op_val      = {16'($urandom), 32'($urandom)};
            checks++;
            if (issue_ready !== ((pv.size() + fq.size()) < DEPTH)) begin
                errors++; $display("FAIL rand_issue_ready n=%0d got %0b", n, issue_ready);
            end
            checks++;
            if (level !== CW'(fq.size()) || in_flight !== CW'(pv.size())) begin
                errors++; $display("FAIL rand_counts n=%0d got level %0d in_flight %0d want %0d %0d",
                                   n, level, in_flight, fq.size(), pv.size());
            end
            checks++;
            if (out_valid !== (fq.size() != 0)) begin
                errors++; $display("FAIL rand_out_valid n=%0d got %0b want %0b", n, out_valid, fq.size() != 0);
            end
            if (fq.size() != 0) begin
                checks++;
                if (out_data !== fq[0]) begin
                    errors++; $display("FAIL rand_out_data n=%0d got %h want %h", n, out_data, fq[0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 0; ce = 1; flush = 0; issue_valid = 0; out_ready = 0;
        p_in = '0; op_val = '0;
        for (int i = 0; i < LAT; i++) dp[i] = '0;
        #2;
        test_reset();
        #10 rst_n = 1;
        @(posedge clk);
        #1;
        test_single();
        test_credit_fill();
        test_ce_stall();
        test_back_to_back();
        test_async_reset();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
